// File: rtl/multdiv_unit.sv
// Sequential 32-bit signed multiply/divide unit: radix-2 Booth multiply and
// non-restoring magnitude divide, 33 cycles from start edge to result strobe.
module multdiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_mult = 2'd1,
      st_div  = 2'd2,
      st_done = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic        start_s;
   logic        last_iter_s;
   logic        finish_s;
   logic [31:0] res_s;
   logic        exc_s;
   logic [63:0] prod64_s;
   logic [5:0]  cnt_r;
   logic        is_div_r;
   logic [31:0] opa_r;
   logic [31:0] opb_r;
   logic [64:0] prod_r;
   logic [33:0] rem_r;
   logic [31:0] quo_r;
   logic [65:0] div_next_s;

   function automatic logic [31:0] mag(input logic [31:0] x);
      logic [31:0] m;
      if (x[31]) begin
         m = 32'd0 - x;
      end else begin
         m = x;
      end
      return m;
   endfunction

   // The add is done one bit wider so subtracting 0x80000000 keeps its true sign
   // through the arithmetic shift.
   function automatic logic [64:0] booth_step(input logic [64:0] p, input logic [31:0] m);
      logic [32:0] acc;
      acc = {p[64], p[64:33]};
      case (p[1:0])
         2'b01:   acc = acc + {m[31], m};
         2'b10:   acc = acc - {m[31], m};
         default: acc = acc;
      endcase
      return {acc, p[32:1]};
   endfunction

   // Quotient bit is 1 whenever the partial remainder stays non-negative.
   function automatic logic [65:0] div_step(input logic [33:0] r, input logic [31:0] q,
                                            input logic [31:0] d);
      logic [33:0] sh;
      logic [33:0] nr;
      sh = {r[32:0], q[31]};
      if (r[33]) begin
         nr = sh + {2'b00, d};
      end else begin
         nr = sh - {2'b00, d};
      end
      return {nr, q[30:0], ~nr[33]};
   endfunction

   assign start_s     = ctrl_MULT | ctrl_DIV;
   assign last_iter_s = (cnt_r == 6'd31);
   assign prod64_s    = prod_r[64:1];
   assign div_next_s  = div_step(rem_r, quo_r, mag(opb_r));

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= st_idle;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a start edge overrides everything, multiply first.
   always_comb begin
      state_next_s = state_r;
      if (start_s) begin
         if (ctrl_MULT) begin
            state_next_s = st_mult;
         end else begin
            state_next_s = st_div;
         end
      end else begin
         case (state_r)
            st_mult, st_div: begin
               if (last_iter_s) begin
                  state_next_s = st_done;
               end else begin
                  state_next_s = state_r;
               end
            end
            st_done: state_next_s = st_idle;
            st_idle: state_next_s = st_idle;
            default: state_next_s = st_idle;
         endcase
      end
   end

   // Output decode: final result, exception and the finish condition.
   always_comb begin
      finish_s = 1'b0;
      res_s    = 32'd0;
      exc_s    = 1'b0;
      if ((state_r == st_done) && !start_s) begin
         finish_s = 1'b1;
      end else begin
         finish_s = 1'b0;
      end
      if (!is_div_r) begin
         res_s = prod64_s[31:0];
         exc_s = (prod64_s[63:32] != {32{prod64_s[31]}});
      end else if (opb_r == 32'd0) begin
         res_s = 32'd0;
         exc_s = 1'b1;
      end else if ((opa_r == 32'h8000_0000) && (opb_r == 32'hFFFF_FFFF)) begin
         res_s = 32'h8000_0000;
         exc_s = 1'b1;
      end else if (opa_r[31] ^ opb_r[31]) begin
         res_s = 32'd0 - quo_r;
         exc_s = 1'b0;
      end else begin
         res_s = quo_r;
         exc_s = 1'b0;
      end
   end

   // Operand capture, iteration counter and Booth / divide datapath.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r    <= 6'd0;
         is_div_r <= 1'b0;
         opa_r    <= 32'd0;
         opb_r    <= 32'd0;
         prod_r   <= 65'd0;
         rem_r    <= 34'd0;
         quo_r    <= 32'd0;
      end else if (start_s) begin
         cnt_r    <= 6'd0;
         is_div_r <= ~ctrl_MULT;
         opa_r    <= data_operandA;
         opb_r    <= data_operandB;
         prod_r   <= {32'd0, data_operandB, 1'b0};
         rem_r    <= 34'd0;
         quo_r    <= mag(data_operandA);
      end else if (state_r == st_mult) begin
         cnt_r  <= cnt_r + 6'd1;
         prod_r <= booth_step(prod_r, opa_r);
      end else if (state_r == st_div) begin
         cnt_r <= cnt_r + 6'd1;
         rem_r <= div_next_s[65:32];
         quo_r <= div_next_s[31:0];
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Registered outputs: results held until the next completion.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_result    <= 32'd0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else if (finish_s) begin
         data_result    <= res_s;
         data_exception <= exc_s;
         data_resultRDY <= 1'b1;
      end else begin
         data_resultRDY <= 1'b0;
      end
   end

endmodule
